// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the fetch-stage sequencing controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MEM_WAIT,
        CTRL_WAIT,
        REDIRECT
    } fetch_ctrl_state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // True when the instruction is a control-flow op that must be resolved by execute.
    function automatic logic is_ctrl_op(input logic [15:0] instr);
        logic [3:0] op;
        op = instr[15:12];
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of decode/execute inputs and fetch-control outputs around fetch_ctrl.
interface fetch_ctrl_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   instr_valid;
    logic [15:0]            instr_dout;
    logic                   mem_req;
    logic                   complete_data;
    logic                   exec_br_valid;
    logic                   exec_br_taken;
    logic [15:0]            exec_taddr;
    logic                   enable_fetch;
    logic                   enable_updatePC;
    logic                   br_taken;
    logic [15:0]            taddr;
    logic                   ctrl_err;
    logic [STALL_CNT_W-1:0] stall_cycles;

    // Pipeline side: drives instruction/execute status, observes fetch control.
    modport master (
        output instr_valid, instr_dout, mem_req, complete_data,
               exec_br_valid, exec_br_taken, exec_taddr,
        input  enable_fetch, enable_updatePC, br_taken, taddr,
               ctrl_err, stall_cycles
    );

    // Controller side.
    modport slave (
        input  instr_valid, instr_dout, mem_req, complete_data,
               exec_br_valid, exec_br_taken, exec_taddr,
        output enable_fetch, enable_updatePC, br_taken, taddr,
               ctrl_err, stall_cycles
    );
endinterface

// File: rtl/fetch_ctrl_stallcnt.sv
// Generic saturating up-counter with synchronous clear.
module fetch_ctrl_stallcnt #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones; clear has priority over inc.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: stalls fetch for unresolved BR/JMP and
// for load/store use of the shared memory port, and issues PC redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_TIMEOUT = 8,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input logic        clock,
    input logic        reset,
    fetch_ctrl_if.slave bus
);

    localparam int unsigned WCNT_W = (CTRL_TIMEOUT > 1) ? $clog2(CTRL_TIMEOUT) : 1;

    fetch_ctrl_state_t state, state_next;

    logic                   pend_ctrl, pend_next;
    logic [15:0]            taddr_q, taddr_next;
    logic                   err_q, err_next;
    logic                   ef_q, ef_next;
    logic                   upd_q, upd_next;
    logic                   br_q, br_next;
    logic [WCNT_W-1:0]      wcnt;
    logic                   wdog_hit;
    logic                   in_stall;
    logic                   in_ctrl_wait;
    logic [STALL_CNT_W-1:0] stall_q;

    assign in_ctrl_wait = (state == CTRL_WAIT);
    assign in_stall     = (state == MEM_WAIT) || (state == CTRL_WAIT) || (state == REDIRECT);
    assign wdog_hit     = (wcnt == WCNT_W'(CTRL_TIMEOUT - 1));

    // Per-visit wait counter: held at zero outside CTRL_WAIT so each visit starts fresh.
    fetch_ctrl_stallcnt #(.W(WCNT_W)) u_wcnt (
        .clock (clock),
        .reset (reset),
        .clear (!in_ctrl_wait),
        .inc   (in_ctrl_wait),
        .count (wcnt)
    );

    // Performance counter of stalled cycles (IDLE is not a stall).
    fetch_ctrl_stallcnt #(.W(STALL_CNT_W)) u_stall (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .inc   (in_stall),
        .count (stall_q)
    );

    // Next-state, side-state and next-output decode; outputs are decoded from
    // the next state so they can be registered alongside it.
    always_comb begin
        state_next = state;
        pend_next  = pend_ctrl;
        taddr_next = taddr_q;
        err_next   = err_q;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (bus.mem_req) begin
                    state_next = MEM_WAIT;
                    if (bus.instr_valid && is_ctrl_op(bus.instr_dout)) begin
                        pend_next = 1'b1;
                    end
                end else if (bus.instr_valid && is_ctrl_op(bus.instr_dout)) begin
                    state_next = CTRL_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.complete_data) begin
                    state_next = pend_ctrl ? CTRL_WAIT : FETCH;
                    pend_next  = 1'b0;
                end
            end
            CTRL_WAIT: begin
                if (bus.exec_br_valid) begin
                    if (bus.exec_br_taken) begin
                        taddr_next = bus.exec_taddr;
                        state_next = REDIRECT;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (wdog_hit) begin
                    err_next   = 1'b1;
                    state_next = FETCH;
                end
            end
            REDIRECT: begin
                state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ef_next  = (state_next == FETCH);
        upd_next = (state_next == FETCH) || (state_next == REDIRECT);
        br_next  = (state_next == REDIRECT);
    end

    // State and registered-output update; reset discards any captured target.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            pend_ctrl <= 1'b0;
            taddr_q   <= '0;
            err_q     <= 1'b0;
            ef_q      <= 1'b0;
            upd_q     <= 1'b0;
            br_q      <= 1'b0;
        end else begin
            state     <= state_next;
            pend_ctrl <= pend_next;
            taddr_q   <= taddr_next;
            err_q     <= err_next;
            ef_q      <= ef_next;
            upd_q     <= upd_next;
            br_q      <= br_next;
        end
    end

    assign bus.enable_fetch    = ef_q;
    assign bus.enable_updatePC = upd_q;
    assign bus.br_taken        = br_q;
    assign bus.taddr           = taddr_q;
    assign bus.ctrl_err        = err_q;
    assign bus.stall_cycles    = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_fetch_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    fetch_ctrl_if #(.STALL_CNT_W(16)) bus ();

    fetch_ctrl #(
        .CTRL_TIMEOUT (8),
        .STALL_CNT_W  (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        ef;
        logic        upd;
        logic        br;
        logic [15:0] ta;
        logic        err;
        logic [15:0] stall;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [15:0] ins, input logic mr,
                          input logic cd, input logic bv, input logic bt,
                          input logic [15:0] ta);
        bus.instr_valid   = iv;
        bus.instr_dout    = ins;
        bus.mem_req       = mr;
        bus.complete_data = cd;
        bus.exec_br_valid = bv;
        bus.exec_br_taken = bt;
        bus.exec_taddr    = ta;
    endtask

    task automatic idle();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic expect_out(input string nm, input logic ef, input logic upd,
                              input logic br, input logic [15:0] ta,
                              input logic err, input logic [15:0] stall);
        exp_t e;
        e.ef    = ef;
        e.upd   = upd;
        e.br    = br;
        e.ta    = ta;
        e.err   = err;
        e.stall = stall;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares the current cycle's outputs against the queued expectation.
    always @(negedge clock) begin
        exp_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (bus.enable_fetch !== e.ef || bus.enable_updatePC !== e.upd ||
                bus.br_taken !== e.br || bus.taddr !== e.ta ||
                bus.ctrl_err !== e.err || bus.stall_cycles !== e.stall) begin
                errors++;
                $display("FAIL %s: got ef=%b upd=%b br=%b taddr=%h err=%b stall=%h, expected ef=%b upd=%b br=%b taddr=%h err=%b stall=%h",
                         nm, bus.enable_fetch, bus.enable_updatePC, bus.br_taken,
                         bus.taddr, bus.ctrl_err, bus.stall_cycles,
                         e.ef, e.upd, e.br, e.ta, e.err, e.stall);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        // Reset release: first cycle still IDLE, fetch starts one cycle later.
        reset = 1'b1;
        expect_out("reset_state", 0, 0, 0, 16'h0000, 0, 16'd0);
        tick();
        expect_out("fetch_start", 1, 1, 0, 16'h0000, 0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out("idle_fetch", 1, 1, 0, 16'h0000, 0, 16'd0);
        end

        // BR taken, resolved three cycles after the fetch.
        tick(); set_in(1, 16'h0E05, 0, 0, 0, 0, 16'h0000);
        expect_out("br_fetch", 1, 1, 0, 16'h0000, 0, 16'd0);
        tick(); idle();
        expect_out("br_wait1", 0, 0, 0, 16'h0000, 0, 16'd0);
        tick(); idle();
        expect_out("br_wait2", 0, 0, 0, 16'h0000, 0, 16'd1);
        tick(); set_in(0, 16'h0000, 0, 0, 1, 1, 16'h3010);
        expect_out("br_wait3", 0, 0, 0, 16'h0000, 0, 16'd2);
        tick(); idle();
        expect_out("br_redirect", 0, 1, 1, 16'h3010, 0, 16'd3);
        tick();
        expect_out("br_resume", 1, 1, 0, 16'h3010, 0, 16'd4);

        // JMP not taken: no redirect pulse, taddr untouched.
        tick(); set_in(1, 16'hC1C0, 0, 0, 0, 0, 16'h0000);
        expect_out("jmp_fetch", 1, 1, 0, 16'h3010, 0, 16'd4);
        tick(); idle();
        expect_out("jmp_wait1", 0, 0, 0, 16'h3010, 0, 16'd4);
        tick(); set_in(0, 16'h0000, 0, 0, 1, 0, 16'h1234);
        expect_out("jmp_wait2", 0, 0, 0, 16'h3010, 0, 16'd5);
        tick(); idle();
        expect_out("jmp_resume", 1, 1, 0, 16'h3010, 0, 16'd6);
        tick();
        expect_out("jmp_fetch2", 1, 1, 0, 16'h3010, 0, 16'd6);

        // mem_req with BR in the same cycle: memory first, then control wait.
        tick(); set_in(1, 16'h0E05, 1, 0, 0, 0, 16'h0000);
        expect_out("mem_br_fetch", 1, 1, 0, 16'h3010, 0, 16'd6);
        tick(); idle();
        expect_out("mem_br_mw1", 0, 0, 0, 16'h3010, 0, 16'd6);
        tick(); set_in(0, 16'h0000, 0, 1, 0, 0, 16'h0000);
        expect_out("mem_br_mw2", 0, 0, 0, 16'h3010, 0, 16'd7);
        tick(); set_in(0, 16'h0000, 0, 0, 1, 1, 16'h4000);
        expect_out("mem_br_cw", 0, 0, 0, 16'h3010, 0, 16'd8);
        tick(); idle();
        expect_out("mem_br_redirect", 0, 1, 1, 16'h4000, 0, 16'd9);
        tick();
        expect_out("mem_br_resume", 1, 1, 0, 16'h4000, 0, 16'd10);

        // Plain load/store: exec_br_valid during MEM_WAIT is ignored.
        tick(); set_in(1, 16'h1234, 1, 0, 0, 0, 16'h0000);
        expect_out("mem_fetch", 1, 1, 0, 16'h4000, 0, 16'd10);
        tick(); set_in(0, 16'h0000, 0, 1, 1, 1, 16'h5555);
        expect_out("mem_wait", 0, 0, 0, 16'h4000, 0, 16'd10);
        tick(); idle();
        expect_out("mem_resume", 1, 1, 0, 16'h4000, 0, 16'd11);

        // Watchdog: eight unresolved CTRL_WAIT cycles.
        tick(); set_in(1, 16'hC1C0, 0, 0, 0, 0, 16'h0000);
        expect_out("wd_fetch", 1, 1, 0, 16'h4000, 0, 16'd11);
        for (int k = 1; k <= 8; k++) begin
            tick(); idle();
            expect_out("wd_wait", 0, 0, 0, 16'h4000, 0, 16'(11 + k - 1));
        end
        tick();
        expect_out("wd_fire", 1, 1, 0, 16'h4000, 1, 16'd19);

        // ctrl_err stays set through a later redirect; reset lands mid-redirect.
        tick(); set_in(1, 16'h0E05, 0, 0, 0, 0, 16'h0000);
        expect_out("err_sticky_fetch", 1, 1, 0, 16'h4000, 1, 16'd19);
        tick(); set_in(0, 16'h0000, 0, 0, 1, 1, 16'hABCD);
        expect_out("err_sticky_wait", 0, 0, 0, 16'h4000, 1, 16'd19);
        tick(); idle();
        expect_out("rst_redirect", 0, 1, 1, 16'hABCD, 1, 16'd20);
        reset = 1'b0;
        tick();
        expect_out("rst_mid", 0, 0, 0, 16'h0000, 0, 16'd0);
        reset = 1'b1;
        tick();
        expect_out("rst_refetch", 1, 1, 0, 16'h0000, 0, 16'd0);

        // Long memory stall saturates the stall counter.
        tick(); set_in(0, 16'h0000, 1, 0, 0, 0, 16'h0000);
        expect_out("sat_fetch", 1, 1, 0, 16'h0000, 0, 16'd0);
        tick(); idle();
        expect_out("sat_mw1", 0, 0, 0, 16'h0000, 0, 16'd0);
        for (int k = 2; k <= 65540; k++) begin
            tick();
            if (k == 65535) expect_out("sat_pre", 0, 0, 0, 16'h0000, 0, 16'hFFFE);
            if (k == 65536) expect_out("sat_hit", 0, 0, 0, 16'h0000, 0, 16'hFFFF);
            if (k == 65540) begin
                expect_out("sat_hold", 0, 0, 0, 16'h0000, 0, 16'hFFFF);
                set_in(0, 16'h0000, 0, 1, 0, 0, 16'h0000);
            end
        end
        tick(); idle();
        expect_out("sat_resume", 1, 1, 0, 16'h0000, 0, 16'hFFFF);
        tick();
        expect_out("sat_after", 1, 1, 0, 16'h0000, 0, 16'hFFFF);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
